// File: rtl/pipe_ifu_prefetch.sv
// Prefetching instruction-fetch stage.
//
// Issues in-order sequential AXI-lite reads (at most MAX_OUTST outstanding) and
// queues the returned words, tagged with their PC, in a FIFO_DEPTH-entry
// instruction queue feeding ID. A flush redirects fetch to flush_pc_i. Responses
// to reads issued before the flush are counted in a drop counter and discarded.
//
// Ports:
//   clk_i, rst_ni              clock, synchronous active-low reset
//   flush_i, flush_pc_i        redirect request and target
//   ifu_ar*                    AXI-lite read address channel (registered outputs)
//   ifu_r*                     AXI-lite read data channel; rready is high out of reset
//   if_valid_o, if_pc_o,
//   if_inst_o, if_fault_o      head of the instruction queue towards ID
//   id_ready_i                 ID accepts the head entry
//
// Optional feature: define IFU_BYPASS_EN to forward a response straight to ID in
// the cycle it arrives when the queue is empty and no stale responses remain.

module pipe_ifu_prefetch #(
  parameter int unsigned           ADDR_WIDTH = 32,
  parameter int unsigned           DATA_WIDTH = 32,
  parameter int unsigned           FIFO_DEPTH = 4,
  parameter int unsigned           MAX_OUTST  = 2,
  parameter logic [ADDR_WIDTH-1:0] RESET_PC   = 32'h2000_0000
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  flush_i,
  input  logic [ADDR_WIDTH-1:0] flush_pc_i,
  output logic [ADDR_WIDTH-1:0] ifu_araddr_o,
  output logic                  ifu_arvalid_o,
  input  logic                  ifu_arready_i,
  input  logic                  ifu_rvalid_i,
  input  logic [DATA_WIDTH-1:0] ifu_rdata_i,
  input  logic [1:0]            ifu_rresp_i,
  output logic                  ifu_rready_o,
  output logic                  if_valid_o,
  output logic [ADDR_WIDTH-1:0] if_pc_o,
  output logic [31:0]           if_inst_o,
  output logic                  if_fault_o,
  input  logic                  id_ready_i
);

  localparam int unsigned CW = $clog2(FIFO_DEPTH + 1);
  localparam int unsigned PW = $clog2(FIFO_DEPTH);

  typedef logic [CW-1:0] cnt_t;
  typedef logic [PW-1:0] ptr_t;

  logic [ADDR_WIDTH-1:0] fetch_pc_q, fetch_pc_d;
  logic [ADDR_WIDTH-1:0] araddr_q, araddr_d;
  logic                  arvalid_q, arvalid_d;
  logic                  ar_stale_q, ar_stale_d;
  logic                  rready_q;
  cnt_t                  outst_q, outst_d;
  cnt_t                  drop_q, drop_d;
  cnt_t                  count_q, count_d;
  ptr_t                  q_wr_q, q_wr_d, q_rd_q, q_rd_d;
  ptr_t                  tag_wr_q, tag_rd_q;

  logic [ADDR_WIDTH-1:0] q_pc_q    [FIFO_DEPTH];
  logic [31:0]           q_inst_q  [FIFO_DEPTH];
  logic                  q_fault_q [FIFO_DEPTH];
  // PC of every accepted AR, consumed in order by R beats (stale ones included).
  logic [ADDR_WIDTH-1:0] tag_pc_q  [FIFO_DEPTH];

  logic ar_fire, ar_hold, ar_fire_stale, r_fire, r_keep;
  logic q_nonempty, bypass, push, pop;
  cnt_t drop_base;

  // Credit counts outstanding reads, queued words and pending drops, so the
  // queue always has room for every response and rready can stay high.
  function automatic logic has_credit(cnt_t o, cnt_t c, cnt_t d);
    return ((32'(o) + 32'(c) + 32'(d)) < FIFO_DEPTH) && (32'(o) < MAX_OUTST);
  endfunction

  assign ar_fire       = arvalid_q & ifu_arready_i;
  assign ar_hold       = arvalid_q & ~ifu_arready_i;
  // An AR raised before a flush (or accepted in the flush cycle) fetches the old path.
  assign ar_fire_stale = ar_fire & (ar_stale_q | flush_i);
  assign r_fire        = ifu_rvalid_i & rready_q;
  assign r_keep        = r_fire & (drop_q == '0) & ~flush_i;
  assign q_nonempty    = (count_q != '0);

`ifdef IFU_BYPASS_EN
  assign bypass = r_keep & ~q_nonempty;
  assign push   = r_keep & ~(bypass & id_ready_i);
`else
  assign bypass = 1'b0;
  assign push   = r_keep;
`endif

  assign pop        = ~flush_i & q_nonempty & id_ready_i;
  assign if_valid_o = ~flush_i & (q_nonempty | bypass);

  always_comb begin
    if_pc_o    = '0;
    if_inst_o  = '0;
    if_fault_o = 1'b0;
    if (q_nonempty) begin
      if_pc_o    = q_pc_q[q_rd_q];
      if_inst_o  = q_inst_q[q_rd_q];
      if_fault_o = q_fault_q[q_rd_q];
    end else if (bypass) begin
      if_pc_o    = tag_pc_q[tag_rd_q];
      if_inst_o  = ifu_rdata_i[31:0];
      if_fault_o = (ifu_rresp_i != 2'b00);
    end
  end

  always_comb begin
    outst_d = outst_q + cnt_t'(ar_fire) - cnt_t'(r_fire);

    if (flush_i) begin
      drop_base = outst_q - cnt_t'(r_fire);
    end else begin
      drop_base = drop_q - cnt_t'(r_fire & (drop_q != '0));
    end
    drop_d = drop_base + cnt_t'(ar_fire_stale);

    if (flush_i) begin
      count_d = '0;
      q_rd_d  = q_wr_q;
    end else begin
      count_d = count_q + cnt_t'(push) - cnt_t'(pop);
      q_rd_d  = pop ? q_rd_q + ptr_t'(1) : q_rd_q;
    end
    q_wr_d = push ? q_wr_q + ptr_t'(1) : q_wr_q;

    // A stale AR does not advance fetch_pc: it already holds the redirect target.
    if (flush_i) begin
      fetch_pc_d = flush_pc_i;
    end else if (ar_fire && !ar_stale_q) begin
      fetch_pc_d = fetch_pc_q + ADDR_WIDTH'(4);
    end else begin
      fetch_pc_d = fetch_pc_q;
    end

    arvalid_d  = ar_hold | has_credit(outst_d, count_d, drop_d);
    araddr_d   = ar_hold ? araddr_q : fetch_pc_d;
    ar_stale_d = ar_hold & (ar_stale_q | flush_i);
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      fetch_pc_q <= RESET_PC;
      araddr_q   <= RESET_PC;
      arvalid_q  <= 1'b0;
      ar_stale_q <= 1'b0;
      rready_q   <= 1'b0;
      outst_q    <= '0;
      drop_q     <= '0;
      count_q    <= '0;
      q_wr_q     <= '0;
      q_rd_q     <= '0;
      tag_wr_q   <= '0;
      tag_rd_q   <= '0;
    end else begin
      fetch_pc_q <= fetch_pc_d;
      araddr_q   <= araddr_d;
      arvalid_q  <= arvalid_d;
      ar_stale_q <= ar_stale_d;
      rready_q   <= 1'b1;
      outst_q    <= outst_d;
      drop_q     <= drop_d;
      count_q    <= count_d;
      q_wr_q     <= q_wr_d;
      q_rd_q     <= q_rd_d;
      if (ar_fire) tag_wr_q <= tag_wr_q + ptr_t'(1);
      if (r_fire)  tag_rd_q <= tag_rd_q + ptr_t'(1);
    end
  end

  always_ff @(posedge clk_i) begin
    if (push) begin
      q_pc_q[q_wr_q]    <= tag_pc_q[tag_rd_q];
      q_inst_q[q_wr_q]  <= ifu_rdata_i[31:0];
      q_fault_q[q_wr_q] <= (ifu_rresp_i != 2'b00);
    end
    if (ar_fire) tag_pc_q[tag_wr_q] <= araddr_q;
  end

  assign ifu_araddr_o  = araddr_q;
  assign ifu_arvalid_o = arvalid_q;
  assign ifu_rready_o  = rready_q;

endmodule
